// File: rtl/element_packer_pkg.sv
// Shared normalization-path types and helpers used by the element packer.
package element_packer_pkg;

    localparam int unsigned MAX_LANES = 64;

    typedef enum logic {
        FILL,
        FLUSH
    } packer_state_t;

    // Lanes 0..n-1 set; callers truncate to their own lane count.
    function automatic logic [MAX_LANES-1:0] prefix_mask(input int unsigned n);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            mask[i] = (i < n);
        end
        return mask;
    endfunction

    function automatic logic [7:0] popcount_keep(input logic [MAX_LANES-1:0] keep);
        logic [7:0] count;
        count = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            count = count + 8'(keep[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/ndata_i.sv
// N-lane element stream with per-lane keep, packet last and valid/ready handshake.
interface ndata_i #(
    parameter type         data_t       = logic [7:0],
    parameter int unsigned NUM_ELEMENTS = 4
);
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;
    logic                     valid;
    logic                     ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/element_packer_barrel_shifter.sv
// Combinational lane rotator: input element i lands in lane (i + offset) mod N.
module element_packer_barrel_shifter #(
    parameter type         data_t       = logic [7:0],
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned OFFSET_WIDTH = $clog2(NUM_ELEMENTS)
) (
    input  data_t [NUM_ELEMENTS-1:0] data_i,
    input  logic  [OFFSET_WIDTH-1:0] offset_i,
    output data_t [NUM_ELEMENTS-1:0] data_o
);
    localparam int unsigned IDX_W = $clog2(NUM_ELEMENTS);

    // Index arithmetic wraps naturally because NUM_ELEMENTS is a power of two.
    always_comb begin
        for (int unsigned j = 0; j < NUM_ELEMENTS; j++) begin
            data_o[j] = data_i[IDX_W'(IDX_W'(j) - IDX_W'(offset_i))];
        end
    end

endmodule

// File: rtl/element_packer.sv
// Packs prefix-valid beats into dense output beats via a residual buffer and fill level.
module element_packer
    import element_packer_pkg::*;
#(
    parameter type         data_t       = logic [7:0],
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned OFFSET_WIDTH = $clog2(NUM_ELEMENTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ndata_i.s                       in,
    ndata_i.m                       out,
    output logic [OFFSET_WIDTH-1:0] fill
);
    localparam int unsigned SW = OFFSET_WIDTH + 1;

    typedef data_t [NUM_ELEMENTS-1:0] vec_t;
    typedef logic  [NUM_ELEMENTS-1:0] mask_t;

    // state | meaning
    // FILL  | accepting input, merging into residual, emitting dense beats
    // FLUSH | input stalled, residual tail of a packet goes out with last=1
    packer_state_t state_q, state_d;

    logic [OFFSET_WIDTH-1:0] fill_q, fill_d;
    vec_t                    resid_q, resid_d;
    vec_t                    out_data_q, out_data_d;
    mask_t                   out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;

    vec_t          in_data, rotated, merged;
    logic [SW-1:0] cnt, sum;
    logic          out_free, in_ready, in_fire;

    assign in_data = in.data;

    element_packer_barrel_shifter #(
        .data_t      (data_t),
        .NUM_ELEMENTS(NUM_ELEMENTS),
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_shifter (
        .data_i  (in_data),
        .offset_i(fill_q),
        .data_o  (rotated)
    );

    always_comb begin
        cnt = SW'(popcount_keep(MAX_LANES'(in.keep)));
        sum = SW'(fill_q) + cnt;
        for (int unsigned j = 0; j < NUM_ELEMENTS; j++) begin
            merged[j] = (j < 32'(fill_q)) ? resid_q[j] : rotated[j];
        end
    end

    assign out_free = !out_valid_q || out.ready;
    assign in_ready = out_free && (state_q == FILL);
    assign in_fire  = in.valid && in_ready;
    assign in.ready = in_ready;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        resid_d     = resid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out.ready;

        case (state_q)
            FILL: begin
                if (in_fire) begin
                    // Low bits of S equal S-N whenever S >= N, and S itself otherwise.
                    fill_d = sum[OFFSET_WIDTH-1:0];
                    if (!in.last) begin
                        if (sum >= SW'(NUM_ELEMENTS)) begin
                            out_valid_d = 1'b1;
                            out_data_d  = merged;
                            out_keep_d  = '1;
                            out_last_d  = 1'b0;
                            resid_d     = rotated;
                        end else begin
                            resid_d = merged;
                        end
                    end else if (sum > SW'(NUM_ELEMENTS)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged;
                        out_keep_d  = '1;
                        out_last_d  = 1'b0;
                        resid_d     = rotated;
                        state_d     = FLUSH;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged;
                        out_keep_d  = mask_t'(prefix_mask(32'(sum)));
                        out_last_d  = 1'b1;
                        fill_d      = '0;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = resid_q;
                    out_keep_d  = mask_t'(prefix_mask(32'(fill_q)));
                    out_last_d  = 1'b1;
                    fill_d      = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_q      <= '0;
            resid_q     <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            resid_q     <= resid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Upstream compactor guarantees a prefix keep; anything else breaks the lane math.
    always_ff @(posedge clk) begin
        if (rst_n && in.valid) begin
            assert (in.keep == mask_t'(prefix_mask(32'(cnt))));
        end
    end

    assign out.valid = out_valid_q;
    assign out.data  = out_data_q;
    assign out.keep  = out_keep_q;
    assign out.last  = out_last_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_element_packer.sv
// Directed bench for element_packer with N=4 byte lanes: vector table plus corner-case sequences.
module tb_element_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] fill;

    ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(4)) in_if ();
    ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(4)) out_if ();

    element_packer #(
        .data_t      (logic [7:0]),
        .NUM_ELEMENTS(4),
        .OFFSET_WIDTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in_if),
        .out  (out_if),
        .fill (fill)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 4; j++) begin
            if (k[j]) m[j*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic drive(input logic v, input logic [3:0] k, input logic l, input logic [31:0] d);
        in_if.valid = v;
        in_if.keep  = k;
        in_if.last  = l;
        in_if.data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        vin;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] data;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
        logic [1:0]  e_fill;
        logic        e_in_ready;
    } vec_t;

    function automatic vec_t mk(input logic vin, input logic [3:0] keep, input logic last,
                                input logic [31:0] data, input logic e_valid,
                                input logic [31:0] e_data, input logic [3:0] e_keep,
                                input logic e_last, input logic [1:0] e_fill,
                                input logic e_in_ready);
        vec_t v;
        v.vin = vin; v.keep = keep; v.last = last; v.data = data;
        v.e_valid = e_valid; v.e_data = e_data; v.e_keep = e_keep;
        v.e_last = e_last; v.e_fill = e_fill; v.e_in_ready = e_in_ready;
        return v;
    endfunction

    // Scoreboard and output monitor for the backpressure stream.
    logic [7:0] sb[$];
    logic       mon_en = 1'b0;
    int         mon_pop = 0;
    logic       stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic [5:0]  prev_ctl;

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                check("bp_hold_data", out_if.data, prev_data);
                check("bp_hold_ctl", 32'({out_if.valid, out_if.keep, out_if.last}), 32'(prev_ctl));
            end
            if (out_if.valid && out_if.ready) begin
                check("bp_keep", 32'(out_if.keep), 32'h0000000F);
                for (int j = 0; j < 4; j++) begin
                    if (out_if.keep[j]) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL bp_sb_underflow: got lane %0d data %h expected nothing", j, out_if.data[j]);
                        end else begin
                            check("bp_lane", 32'(out_if.data[j]), 32'(sb.pop_front()));
                        end
                        mon_pop++;
                    end
                end
            end
            stall_prev = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
            prev_ctl   = {1'b0, out_if.valid, out_if.keep, out_if.last};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   sent;
        int   cyc;
        int   low_cnt;
        logic [31:0] d;

        vecs.push_back(mk(1, 4'b0011, 0, 32'h5555A1A0, 0, 32'h0,        4'h0,    0, 2'd2, 1));
        vecs.push_back(mk(1, 4'b0011, 0, 32'h5555B1B0, 1, 32'hB1B0A1A0, 4'hF,    0, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0011, 0, 32'h5555C1C0, 0, 32'h0,        4'h0,    0, 2'd2, 1));
        vecs.push_back(mk(1, 4'b0011, 0, 32'h5555D1D0, 1, 32'hD1D0C1C0, 4'hF,    0, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h55555555, 0, 32'h0,        4'h0,    0, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0000, 1, 32'h55555555, 1, 32'h0,        4'b0000, 1, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0001, 0, 32'h555555E0, 0, 32'h0,        4'h0,    0, 2'd1, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h55555555, 0, 32'h0,        4'h0,    0, 2'd1, 1));
        vecs.push_back(mk(1, 4'b0111, 0, 32'h55626160, 1, 32'h626160E0, 4'hF,    0, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0011, 1, 32'h55557170, 1, 32'h00007170, 4'b0011, 1, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0111, 0, 32'h55828180, 0, 32'h0,        4'h0,    0, 2'd3, 1));
        vecs.push_back(mk(1, 4'b0011, 1, 32'h55559190, 1, 32'h90828180, 4'hF,    0, 2'd1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 32'h55555555, 1, 32'h00000091, 4'b0001, 1, 2'd0, 1));
        vecs.push_back(mk(1, 4'b0001, 0, 32'h55555510, 0, 32'h0,        4'h0,    0, 2'd1, 1));
        vecs.push_back(mk(1, 4'b1111, 0, 32'h23222120, 1, 32'h22212010, 4'hF,    0, 2'd1, 1));
        vecs.push_back(mk(1, 4'b0000, 1, 32'h55555555, 1, 32'h00000023, 4'b0001, 1, 2'd0, 1));

        out_if.ready = 1'b1;
        drive(0, 4'b0000, 0, 32'h0);
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_if.valid), 32'h0);
        check("rst_out_keep", 32'(out_if.keep), 32'h0);
        check("rst_out_last", 32'(out_if.last), 32'h0);
        check("rst_fill", 32'(fill), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_if.ready), 32'h1);

        foreach (vecs[i]) begin
            drive(vecs[i].vin, vecs[i].keep, vecs[i].last, vecs[i].data);
            if (vecs[i].vin) check($sformatf("tbl%0d_in_ready_pre", i), 32'(in_if.ready), 32'h1);
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(out_if.valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check($sformatf("tbl%0d_keep", i), 32'(out_if.keep), 32'(vecs[i].e_keep));
                check($sformatf("tbl%0d_last", i), 32'(out_if.last), 32'(vecs[i].e_last));
                check($sformatf("tbl%0d_data", i), out_if.data & lane_mask(vecs[i].e_keep),
                      vecs[i].e_data & lane_mask(vecs[i].e_keep));
            end
            check($sformatf("tbl%0d_fill", i), 32'(fill), 32'(vecs[i].e_fill));
            check($sformatf("tbl%0d_in_ready", i), 32'(in_if.ready), 32'(vecs[i].e_in_ready));
        end

        // cnt=3 then cnt=3 last: full beat, then a one-cycle flush stall.
        drive(1, 4'b0111, 0, 32'h55A2A1A0);
        check("fl_a_in_ready", 32'(in_if.ready), 32'h1);
        tick();
        check("fl_a_valid", 32'(out_if.valid), 32'h0);
        check("fl_a_fill", 32'(fill), 32'h3);
        drive(1, 4'b0111, 1, 32'h55B2B1B0);
        check("fl_b_in_ready", 32'(in_if.ready), 32'h1);
        tick();
        check("fl_full_valid", 32'(out_if.valid), 32'h1);
        check("fl_full_data", out_if.data, 32'hB0A2A1A0);
        check("fl_full_keep", 32'(out_if.keep), 32'hF);
        check("fl_full_last", 32'(out_if.last), 32'h0);
        check("fl_stall_in_ready", 32'(in_if.ready), 32'h0);
        drive(0, 4'b0000, 0, 32'h55555555);
        tick();
        check("fl_tail_valid", 32'(out_if.valid), 32'h1);
        check("fl_tail_data", out_if.data & lane_mask(4'b0011), 32'h0000B2B1);
        check("fl_tail_keep", 32'(out_if.keep), 32'h3);
        check("fl_tail_last", 32'(out_if.last), 32'h1);
        check("fl_tail_in_ready", 32'(in_if.ready), 32'h1);
        check("fl_tail_fill", 32'(fill), 32'h0);

        // Ten full beats back to back.
        for (int k = 0; k < 10; k++) begin
            d = 32'h03020100 + 32'h04040404 * 32'(k);
            drive(1, 4'b1111, 0, d);
            check($sformatf("full%0d_in_ready", k), 32'(in_if.ready), 32'h1);
            tick();
            check($sformatf("full%0d_valid", k), 32'(out_if.valid), 32'h1);
            check($sformatf("full%0d_data", k), out_if.data, d);
            check($sformatf("full%0d_fill", k), 32'(fill), 32'h0);
        end
        drive(0, 4'b0000, 0, 32'h0);
        tick();

        // Single-element stream with the output stalled for the first five cycles.
        mon_en = 1'b1;
        sent = 0;
        cyc = 0;
        low_cnt = 0;
        while ((sent < 12 || sb.size() != 0 || out_if.valid) && cyc < 200) begin
            out_if.ready = (cyc >= 5);
            if (sent < 12) drive(1, 4'b0001, 0, {24'h555555, 8'h40 + 8'(sent)});
            else drive(0, 4'b0000, 0, 32'h0);
            @(negedge clk);
            if (in_if.valid && in_if.ready) begin
                sb.push_back(8'h40 + 8'(sent));
                sent++;
            end
            if (in_if.valid && !in_if.ready) low_cnt++;
            tick();
            cyc++;
        end
        @(negedge clk);
        mon_en = 1'b0;
        out_if.ready = 1'b1;
        check("bp_in_time", 32'(cyc < 200), 32'h1);
        check("bp_sent", 32'(sent), 32'd12);
        check("bp_popped", 32'(mon_pop), 32'd12);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        check("bp_ready_dropped", 32'(low_cnt != 0), 32'h1);
        check("bp_fill", 32'(fill), 32'h0);
        tick();

        // Reset mid-packet with a residual of three elements.
        drive(1, 4'b0111, 0, 32'h55D2D1D0);
        tick();
        drive(1, 4'b1111, 0, 32'hF3F2F1F0);
        tick();
        check("mid_pre_valid", 32'(out_if.valid), 32'h1);
        check("mid_pre_fill", 32'(fill), 32'h3);
        drive(0, 4'b0000, 0, 32'h0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_if.valid), 32'h0);
        check("mid_rst_fill", 32'(fill), 32'h0);
        rst_n = 1'b1;
        drive(1, 4'b0011, 1, 32'h5555E1E0);
        tick();
        check("mid_post_valid", 32'(out_if.valid), 32'h1);
        check("mid_post_keep", 32'(out_if.keep), 32'h3);
        check("mid_post_last", 32'(out_if.last), 32'h1);
        check("mid_post_data", out_if.data & lane_mask(4'b0011), 32'h0000E1E0);
        check("mid_post_fill", 32'(fill), 32'h0);
        drive(0, 4'b0000, 0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
